complex_accum: RTL and testbench
================================

# complex_accum

Accumulates a frame of LEN complex products and emits the complex sum. Sits directly downstream of `complex_mult`: consumes its `p_valid`/`pr`/`pi` stream (no backpressure upstream, so every valid product is taken) and presents each frame sum on a ready/valid output port. Accumulation of the next frame continues while a finished sum waits for the consumer.

## Interface
- `WIDTH`, 5: width of each input part; matches `complex_mult` output width (2·N+1).
- `LEN`, 4: products per frame, ≥2.
- `GUARD`, 2: extra accumulator bits; `ACC_W = WIDTH + GUARD`.
- `SATURATE`, "ON": "ON" clamps each add to the ACC_W signed range; "OFF" wraps.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `p_valid`  in  1  product valid.
- `pr`, `pi`  in  WIDTH signed  product real/imag.
- `clear`  in  1  synchronous frame restart.
- `s_valid`  out  1  sum valid.
- `s_ready`  in  1  consumer accepts sum.
- `sr`, `si`  out  ACC_W signed  frame sum real/imag.
- `s_ovf`  out  1  saturation/wrap occurred in this frame's sum.
- `overrun`  out  1  sticky: a completed frame was dropped.

## Operation
- Input side FSM: IDLE (cnt=0) → ACCUM on accepted `p_valid`. ACCUM → IDLE when the LEN-th product is accepted. ACCUM → IDLE on `clear` with no concurrent `p_valid`.
- Each accepted product: `acc_r += sext(pr)`, `acc_i += sext(pi)`, `cnt += 1`. The add uses a saturating adder when SATURATE="ON". Any clamp (or signed overflow in "OFF" mode) sets the frame overflow flag `fovf`.
- First product of a frame loads the accumulators with `sext(p)`; no separate zeroing cycle is needed.
- Frame completion (LEN-th product): the sum (acc+p) and `fovf | this-add-ovf` load the output register if it is free. The register is free when `!s_valid`, or when `s_valid && s_ready` in the same cycle. Accumulators and `cnt` restart at 0.
- If the output register is not free at completion, the new sum is dropped, the held sum is unchanged, and `overrun` is set. `overrun` clears only on reset.
- Output: `s_valid` holds with stable `sr`/`si`/`s_ovf` until `s_valid && s_ready`. After acceptance it drops next cycle unless a new sum loads in that same cycle.
- `clear`: discards the partial frame and clears `fovf`. A `p_valid` in the same cycle becomes product 1 of a new frame (cnt=1). `clear` never affects the output register or `overrun`.
- Reset mid-frame: partial sum is lost and the held output is lost.
- Reset values: `s_valid`=0, `sr`=`si`=0, `s_ovf`=0, `overrun`=0, cnt=0, FSM=IDLE.

## Timing
- Latency: LEN-th product accepted at edge t → `s_valid`=1 with its sum after edge t (visible in cycle t+1).
- Throughput: one product per cycle. Back-to-back frames are sustained when `s_ready` is held high.
- Gaps in `p_valid` are allowed anywhere in a frame.
- Completion and `s_ready` acceptance in the same cycle: the old sum retires and the new sum loads. No bubble, no overrun.

## Structure
- Shared package/header holds the FSM state encodings (IDLE, ACCUM), a `clog2` function for the `cnt` width, and the SATURATE string constants.
- One sub-module, `sat_add`, parameterised by width and saturate mode. It returns the sum and an overflow bit. It is instantiated twice (real, imag).

## Test plan
- Reset: assert `rst_n`=0 mid-frame with `s_valid`=1 → all outputs 0 immediately; the next frame sums from scratch.
- Basic frame: products (1,2),(3,−1),(−2,0),(4,4) back-to-back, `s_ready`=1 → `s_valid` one cycle after the 4th product, `sr`=6, `si`=5, `s_ovf`=0.
- Gapped input: same four products with 0–3 idle cycles between each → identical result and latency relative to the last product.
- Backpressure: `s_ready`=0; frame A (sum 6,5) completes, then frame B completes → `sr`/`si` stay 6/5, `overrun`=1. With `s_ready`=1 at B's completion cycle instead → B loads, `overrun`=0.
- Saturation (GUARD=1, ACC_W=6): four products (15,−16) → `sr`=31, `si`=−32, `s_ovf`=1. With SATURATE="OFF" → `sr`=−4, `si`=0, `s_ovf`=1.
- Clear: products (7,7),(7,7), then `clear` together with (5,5), then (1,1)×3 → sum (8,8). `s_valid` is not asserted for the discarded partial frame.

Source files
------------

// File: rtl/complex_accum_pkg.sv
// Shared definitions for the complex frame accumulator: input FSM states,
// saturation mode names and a ceiling-log2 helper for sizing the product counter.
package complex_accum_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    localparam string SAT_ON  = "ON";
    localparam string SAT_OFF = "OFF";

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/complex_accum_sat_add.sv
// Signed W-bit adder that either clamps to the signed range or wraps,
// and reports signed overflow in both modes.
module sat_add
    import complex_accum_pkg::*;
#(
    parameter int    W        = 7,
    parameter string SAT_MODE = SAT_ON
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    localparam bit SAT_EN = (SAT_MODE == SAT_ON);

    logic [W:0] full_s;

    // One extra bit exposes overflow as a mismatch of the two top bits
    always_comb begin
        full_s = {a[W-1], a} + {b[W-1], b};
        ovf    = full_s[W] ^ full_s[W-1];
        if (ovf && SAT_EN) begin
            sum = full_s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum = full_s[W-1:0];
        end
    end

endmodule

// File: rtl/complex_accum.sv
// Accumulates LEN complex products per frame and offers each frame sum on a
// ready/valid port; the next frame keeps accumulating while a sum is held.
module complex_accum
    import complex_accum_pkg::*;
#(
    parameter int    WIDTH    = 5,
    parameter int    LEN      = 4,
    parameter int    GUARD    = 2,
    parameter string SATURATE = SAT_ON
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           p_valid,
    input  logic signed [WIDTH-1:0]        pr,
    input  logic signed [WIDTH-1:0]        pi,
    input  logic                           clear,
    output logic                           s_valid,
    input  logic                           s_ready,
    output logic signed [WIDTH+GUARD-1:0]  sr,
    output logic signed [WIDTH+GUARD-1:0]  si,
    output logic                           s_ovf,
    output logic                           overrun
);

    localparam int ACC_W = WIDTH + GUARD;
    localparam int CNT_W = clog2(LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    acc_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    logic                   fovf_q, fovf_d;
    logic                   s_valid_q, s_valid_d;
    logic signed [ACC_W-1:0] sr_q, sr_d, si_q, si_d;
    logic                   s_ovf_q, s_ovf_d;
    logic                   overrun_q, overrun_d;

    logic                   first_s, last_s, free_s, add_ovf_s;
    logic [CNT_W-1:0]       cnt_base_s;
    logic signed [ACC_W-1:0] add_a_r_s, add_a_i_s, sext_pr_s, sext_pi_s;
    logic signed [ACC_W-1:0] sum_r_s, sum_i_s;
    logic                   ovf_r_s, ovf_i_s;

    sat_add #(.W(ACC_W), .SAT_MODE(SATURATE)) u_add_re (
        .a   (add_a_r_s),
        .b   (sext_pr_s),
        .sum (sum_r_s),
        .ovf (ovf_r_s)
    );

    sat_add #(.W(ACC_W), .SAT_MODE(SATURATE)) u_add_im (
        .a   (add_a_i_s),
        .b   (sext_pi_s),
        .sum (sum_i_s),
        .ovf (ovf_i_s)
    );

    // A frame's first product (or one arriving with clear) adds onto zero, so no zeroing cycle is needed
    always_comb begin
        first_s    = (state_q == IDLE) || clear;
        cnt_base_s = first_s ? {CNT_W{1'b0}} : cnt_q;
        add_a_r_s  = first_s ? {ACC_W{1'b0}} : acc_r_q;
        add_a_i_s  = first_s ? {ACC_W{1'b0}} : acc_i_q;
        sext_pr_s  = {{GUARD{pr[WIDTH-1]}}, pr};
        sext_pi_s  = {{GUARD{pi[WIDTH-1]}}, pi};
        add_ovf_s  = (first_s ? 1'b0 : fovf_q) | ovf_r_s | ovf_i_s;
        last_s     = p_valid && (cnt_base_s == LAST_CNT);
        free_s     = !s_valid_q || s_ready;
    end

    // Input-side FSM, accumulators and the output register next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_r_d   = acc_r_q;
        acc_i_d   = acc_i_q;
        fovf_d    = fovf_q;
        s_valid_d = s_valid_q;
        sr_d      = sr_q;
        si_d      = si_q;
        s_ovf_d   = s_ovf_q;
        overrun_d = overrun_q;

        if (p_valid) begin
            if (last_s) begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                acc_r_d = {ACC_W{1'b0}};
                acc_i_d = {ACC_W{1'b0}};
                fovf_d  = 1'b0;
            end else begin
                state_d = ACCUM;
                cnt_d   = cnt_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
                acc_r_d = sum_r_s;
                acc_i_d = sum_i_s;
                fovf_d  = add_ovf_s;
            end
        end else if (clear) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
            acc_r_d = {ACC_W{1'b0}};
            acc_i_d = {ACC_W{1'b0}};
            fovf_d  = 1'b0;
        end else begin
            state_d = state_q;
        end

        // A completed frame that finds the register occupied is dropped and flagged
        if (last_s && free_s) begin
            s_valid_d = 1'b1;
            sr_d      = sum_r_s;
            si_d      = sum_i_s;
            s_ovf_d   = add_ovf_s;
        end else if (last_s) begin
            overrun_d = 1'b1;
        end else if (s_valid_q && s_ready) begin
            s_valid_d = 1'b0;
        end else begin
            s_valid_d = s_valid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            acc_r_q   <= {ACC_W{1'b0}};
            acc_i_q   <= {ACC_W{1'b0}};
            fovf_q    <= 1'b0;
            s_valid_q <= 1'b0;
            sr_q      <= {ACC_W{1'b0}};
            si_q      <= {ACC_W{1'b0}};
            s_ovf_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_r_q   <= acc_r_d;
            acc_i_q   <= acc_i_d;
            fovf_q    <= fovf_d;
            s_valid_q <= s_valid_d;
            sr_q      <= sr_d;
            si_q      <= si_d;
            s_ovf_q   <= s_ovf_d;
            overrun_q <= overrun_d;
        end
    end

    assign s_valid = s_valid_q;
    assign sr      = sr_q;
    assign si      = si_q;
    assign s_ovf   = s_ovf_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_complex_accum.sv
// Drives three accumulators (ACC_W=7 saturating, ACC_W=6 saturating, ACC_W=6 wrapping)
// with shared stimulus and checks every cycle against a frame-level reference model.
module tb_complex_accum;
    import complex_accum_pkg::*;

    localparam int NDUT = 3;
    localparam int LEN  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic p_valid = 1'b0;
    logic clear = 1'b0;
    logic s_ready = 1'b0;
    logic signed [4:0] pr = 5'sd0;
    logic signed [4:0] pi = 5'sd0;

    logic [NDUT-1:0] sv, so, ov;
    logic signed [6:0] sr0, si0;
    logic signed [5:0] sr1, si1, sr2, si2;

    int checks = 0;
    int errors = 0;

    int acc_w[NDUT] = '{7, 6, 6};
    bit sat_m[NDUT] = '{1'b1, 1'b1, 1'b0};

    bit m_valid, m_overrun;
    int m_sr[NDUT];
    int m_si[NDUT];
    bit m_ovf[NDUT];
    int fq_r[$];
    int fq_i[$];

    always #5 clk = ~clk;

    complex_accum #(.WIDTH(5), .LEN(LEN), .GUARD(2), .SATURATE("ON")) u_dut0 (
        .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .pr(pr), .pi(pi), .clear(clear),
        .s_valid(sv[0]), .s_ready(s_ready), .sr(sr0), .si(si0), .s_ovf(so[0]), .overrun(ov[0]));

    complex_accum #(.WIDTH(5), .LEN(LEN), .GUARD(1), .SATURATE("ON")) u_dut1 (
        .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .pr(pr), .pi(pi), .clear(clear),
        .s_valid(sv[1]), .s_ready(s_ready), .sr(sr1), .si(si1), .s_ovf(so[1]), .overrun(ov[1]));

    complex_accum #(.WIDTH(5), .LEN(LEN), .GUARD(1), .SATURATE("OFF")) u_dut2 (
        .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .pr(pr), .pi(pi), .clear(clear),
        .s_valid(sv[2]), .s_ready(s_ready), .sr(sr2), .si(si2), .s_ovf(so[2]), .overrun(ov[2]));

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_sr(input int k);
        return (k == 0) ? int'(sr0) : ((k == 1) ? int'(sr1) : int'(sr2));
    endfunction

    function automatic int get_si(input int k);
        return (k == 0) ? int'(si0) : ((k == 1) ? int'(si1) : int'(si2));
    endfunction

    // Sum a list of values in a w-bit signed accumulator, clamping or wrapping each add
    function automatic void frame_sum(input int w, input bit sat, input int v[$],
                                      output int s, output bit ovf);
        int lo;
        int hi;
        lo  = -(1 << (w - 1));
        hi  = (1 << (w - 1)) - 1;
        s   = 0;
        ovf = 1'b0;
        foreach (v[k]) begin
            s = s + v[k];
            if (s > hi) begin
                ovf = 1'b1;
                s   = sat ? hi : s - (1 << w);
            end else if (s < lo) begin
                ovf = 1'b1;
                s   = sat ? lo : s + (1 << w);
            end
        end
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        fq_r.delete();
        fq_i.delete();
        for (int k = 0; k < NDUT; k++) begin
            m_sr[k]  = 0;
            m_si[k]  = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    // Applies one clock edge worth of behaviour, using the inputs held across that edge
    task automatic model_edge();
        bit accepted;
        bit done;
        bit oa;
        bit ob;
        accepted = m_valid && s_ready;
        done     = 1'b0;
        if (clear) begin
            fq_r.delete();
            fq_i.delete();
        end
        if (p_valid) begin
            fq_r.push_back(int'(pr));
            fq_i.push_back(int'(pi));
            if (fq_r.size() == LEN) begin
                done = 1'b1;
                if (!m_valid || s_ready) begin
                    m_valid = 1'b1;
                    for (int k = 0; k < NDUT; k++) begin
                        frame_sum(acc_w[k], sat_m[k], fq_r, m_sr[k], oa);
                        frame_sum(acc_w[k], sat_m[k], fq_i, m_si[k], ob);
                        m_ovf[k] = oa | ob;
                    end
                end else begin
                    m_overrun = 1'b1;
                end
                fq_r.delete();
                fq_i.delete();
            end
        end
        if (!done && accepted) m_valid = 1'b0;
    endtask

    task automatic compare_all();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("d%0d_s_valid", k), int'(sv[k]), int'(m_valid));
            check($sformatf("d%0d_overrun", k), int'(ov[k]), int'(m_overrun));
            if (m_valid) begin
                check($sformatf("d%0d_sr", k), get_sr(k), m_sr[k]);
                check($sformatf("d%0d_si", k), get_si(k), m_si[k]);
                check($sformatf("d%0d_s_ovf", k), int'(so[k]), int'(m_ovf[k]));
            end
        end
    endtask

    // Called at a falling edge: drive, cross one rising edge, compare at the next falling edge
    task automatic step(input bit pv, input int r, input int i, input bit clr, input bit rdy);
        p_valid = pv;
        pr      = 5'(r);
        pi      = 5'(i);
        clear   = clr;
        s_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        p_valid = 1'b0;
        clear   = 1'b0;
        s_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_d%0d_s_valid", k), int'(sv[k]), 0);
            check($sformatf("rst_d%0d_sr", k), get_sr(k), 0);
            check($sformatf("rst_d%0d_si", k), get_si(k), 0);
            check($sformatf("rst_d%0d_s_ovf", k), int'(so[k]), 0);
            check($sformatf("rst_d%0d_overrun", k), int'(ov[k]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int base_r[LEN] = '{1, 3, -2, 4};
    int base_i[LEN] = '{2, -1, 0, 4};

    task automatic basic_frame(input int max_gap, input bit rdy);
        for (int n = 0; n < LEN; n++) begin
            if (n > 0) begin
                int g;
                g = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
                for (int j = 0; j < g; j++) step(1'b0, 0, 0, 1'b0, rdy);
            end
            step(1'b1, base_r[n], base_i[n], 1'b0, rdy);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic frame, then retire
        basic_frame(0, 1'b1);
        check("basic_s_valid", int'(sv[0]), 1);
        check("basic_sr", int'(sr0), 6);
        check("basic_si", int'(si0), 5);
        check("basic_s_ovf", int'(so[0]), 0);
        step(1'b0, 0, 0, 1'b0, 1'b1);

        // Gapped input, same result one cycle after the last product
        for (int rep = 0; rep < 3; rep++) begin
            basic_frame(3, 1'b1);
            check("gap_sr", int'(sr0), 6);
            check("gap_si", int'(si0), 5);
            step(1'b0, 0, 0, 1'b0, 1'b1);
        end

        // Backpressure: second frame dropped
        do_reset();
        basic_frame(0, 1'b0);
        for (int n = 0; n < LEN; n++) step(1'b1, 1, 1, 1'b0, 1'b0);
        check("bp_hold_sr", int'(sr0), 6);
        check("bp_hold_si", int'(si0), 5);
        check("bp_overrun", int'(ov[0]), 1);

        // Backpressure released exactly at the completion cycle
        do_reset();
        basic_frame(0, 1'b0);
        for (int n = 0; n < LEN - 1; n++) step(1'b1, 1, 1, 1'b0, 1'b0);
        step(1'b1, 1, 1, 1'b0, 1'b1);
        check("bp_swap_valid", int'(sv[0]), 1);
        check("bp_swap_sr", int'(sr0), 4);
        check("bp_swap_overrun", int'(ov[0]), 0);
        step(1'b0, 0, 0, 1'b0, 1'b1);

        // Saturation versus wrap
        for (int n = 0; n < LEN; n++) step(1'b1, 15, -16, 1'b0, 1'b1);
        check("sat_on_sr", int'(sr1), 31);
        check("sat_on_si", int'(si1), -32);
        check("sat_on_ovf", int'(so[1]), 1);
        check("sat_off_sr", int'(sr2), -4);
        check("sat_off_si", int'(si2), 0);
        check("sat_off_ovf", int'(so[2]), 1);
        check("sat_wide_ovf", int'(so[0]), 0);
        step(1'b0, 0, 0, 1'b0, 1'b1);

        // Clear restarts the frame with a concurrent product
        step(1'b1, 7, 7, 1'b0, 1'b1);
        step(1'b1, 7, 7, 1'b0, 1'b1);
        step(1'b1, 5, 5, 1'b1, 1'b1);
        step(1'b1, 1, 1, 1'b0, 1'b1);
        step(1'b1, 1, 1, 1'b0, 1'b1);
        check("clr_no_early_valid", int'(sv[0]), 0);
        step(1'b1, 1, 1, 1'b0, 1'b1);
        check("clr_sr", int'(sr0), 8);
        check("clr_si", int'(si0), 8);
        step(1'b0, 0, 0, 1'b0, 1'b1);

        // Reset mid-frame with a held sum, then a clean frame
        basic_frame(0, 1'b0);
        step(1'b1, 9, 9, 1'b0, 1'b0);
        step(1'b1, 9, 9, 1'b0, 1'b0);
        do_reset();
        basic_frame(0, 1'b1);
        check("post_rst_sr", int'(sr0), 6);
        check("post_rst_si", int'(si0), 5);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(9) < 7, int'($urandom_range(31)) - 16,
                 int'($urandom_range(31)) - 16, $urandom_range(19) == 0,
                 $urandom_range(9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
